// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that time-shares one combinational ALU between two requesters.
// IDLE accepts one request, EXEC drives the ALU from latched operands, RESP holds the result for the owner.
module alu_share_ctrl #(
    parameter int DW  = 32,
    parameter int OPW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_result,
    output logic          rsp0_equal,
    output logic          rsp0_err,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_result,
    output logic          rsp1_equal,
    output logic          rsp1_err,
    output logic [DW-1:0] alu_srca,
    output logic [DW-1:0] alu_srcb,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_equal,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_ILL  = OPW'(4);
    localparam logic [OPW-1:0] OP_PASS = OPW'(5);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(7);

    state_t         state;
    logic           last_grant;
    logic           owner;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  res_q;
    logic           eq_q;
    logic           err_q;
    logic           rsp0_vld;
    logic           rsp1_vld;
    logic           any_req;
    logic           grant;
    logic           rsp_take;

    // Packs {err, equal, result} from the raw ALU outputs according to the latched opcode.
    function automatic logic [DW+1:0] post_proc(input logic [OPW-1:0] op,
                                                 input logic [DW-1:0] res,
                                                 input logic eq,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic [DW+1:0] r;
        r = '0;
        case (op)
            OP_CMP:  r = {1'b0, eq, {DW{1'b0}}};
            OP_PASS: r = {1'b0, (b != '0), a};
            OP_ILL:  r = {1'b1, 1'b0, {DW{1'b0}}};
            default: r = {1'b0, 1'b1, res};
        endcase
        return r;
    endfunction

    // Tie goes to the port that did not win last time.
    assign any_req    = req0_valid | req1_valid;
    assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) && any_req && !grant;
    assign req1_ready = (state == IDLE) && any_req && grant;
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            eq_q       <= 1'b0;
            err_q      <= 1'b0;
            rsp0_vld   <= 1'b0;
            rsp1_vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q        <= grant ? req1_a : req0_a;
                        b_q        <= grant ? req1_b : req0_b;
                        op_q       <= grant ? req1_op : req0_op;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    {err_q, eq_q, res_q} <= post_proc(op_q, alu_result, alu_equal, a_q, b_q);
                    rsp0_vld <= ~owner;
                    rsp1_vld <= owner;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_vld <= 1'b0;
                        rsp1_vld <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The ALU sees live operands only during EXEC; the illegal opcode is replaced by a harmless ADD.
    assign alu_srca = (state == EXEC) ? a_q : '0;
    assign alu_srcb = (state == EXEC) ? b_q : '0;
    assign alu_op   = ((state == EXEC) && (op_q != OP_ILL)) ? op_q : OP_ADD;

    assign rsp0_valid  = rsp0_vld;
    assign rsp1_valid  = rsp1_vld;
    assign rsp0_result = owner ? '0 : res_q;
    assign rsp0_equal  = owner ? 1'b0 : eq_q;
    assign rsp0_err    = owner ? 1'b0 : err_q;
    assign rsp1_result = owner ? res_q : '0;
    assign rsp1_equal  = owner ? eq_q : 1'b0;
    assign rsp1_err    = owner ? err_q : 1'b0;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and per-port response scoreboards.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_equal, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_equal, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]  alu_op;
    logic        alu_equal;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    int          grants[$];

    alu_share_ctrl #(.DW(32), .OPW(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_equal(rsp0_equal), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_equal(rsp1_equal), .rsp1_err(rsp1_err),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .alu_result(alu_result), .alu_equal(alu_equal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; compare and pass produce a junk result the controller must not forward.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_op)
            3'd0: alu_result = alu_srca & alu_srcb;
            3'd1: alu_result = alu_srca | alu_srcb;
            3'd2: alu_result = alu_srca + alu_srcb;
            3'd3: alu_result = (alu_srca < alu_srcb) ? 32'd1 : 32'd0;
            3'd6: alu_result = alu_srca - alu_srcb;
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_equal = (alu_srca == alu_srcb);
    end

    // Expected {err, equal, result} for one request.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return {2'b01, a & b};
            3'd1: return {2'b01, a | b};
            3'd2: return {2'b01, a + b};
            3'd3: return {2'b01, (a < b) ? 32'd1 : 32'd0};
            3'd6: return {2'b01, a - b};
            3'd7: return {1'b0, (a == b), 32'd0};
            3'd5: return {1'b0, (b != 32'd0), a};
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        logic [33:0] e;
        if (reset_n) begin
            if (req0_valid && req0_ready) begin q0.push_back(model(req0_a, req0_b, req0_op)); grants.push_back(0); end
            if (req1_valid && req1_ready) begin q1.push_back(model(req1_a, req1_b, req1_op)); grants.push_back(1); end
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
                else begin e = q0.pop_front(); chk("rsp0_data", {rsp0_err, rsp0_equal, rsp0_result}, e); end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
                else begin e = q1.pop_front(); chk("rsp1_data", {rsp1_err, rsp1_equal, rsp1_result}, e); end
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete(); grants.delete();
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy && !rsp0_valid && !rsp1_valid) break;
            tick();
        end
        chk({tag, "_drain_busy"}, busy, 0);
    endtask

    task automatic single(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [2:0] exp_aluop, input string tag);
        if (port == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        else begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        #1;
        chk({tag, "_req_ready"}, (port == 0) ? req0_ready : req1_ready, 1);
        tick();
        req0_valid = 0; req1_valid = 0;
        chk({tag, "_exec_aluop"}, alu_op, exp_aluop);
        chk({tag, "_exec_srca"}, alu_srca, a);
        chk({tag, "_exec_busy"}, busy, 1);
        tick();
        chk({tag, "_rsp_valid"}, (port == 0) ? rsp0_valid : rsp1_valid, 1);
        chk({tag, "_resp_aluop"}, alu_op, 3'd2);
        tick();
        chk({tag, "_rsp_done"}, (port == 0) ? rsp0_valid : rsp1_valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [31:0] held;
        reset_n = 0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;

        // Reset and idle
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        reset_n = 1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_req_ready", {req0_ready, req1_ready}, 0);
        chk("idle_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("idle_rsp_data", {rsp0_result, rsp0_equal, rsp0_err, rsp1_result, rsp1_equal, rsp1_err}, 0);
        chk("idle_alu", {alu_srca, alu_srcb, alu_op}, {64'd0, 3'd2});

        // Single ADD with overflow into the sign bit
        rsp0_ready = 1; rsp1_ready = 1;
        single(0, 32'h7FFFFFFF, 32'd1, 3'd2, 3'd2, "add");

        // Tie and fairness from a fresh reset
        do_reset();
        req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 3'd6;
        req1_valid = 1; req1_a = 3; req1_b = 3; req1_op = 3'd7;
        #1;
        chk("tie_first_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        chk("tie_exec_aluop", alu_op, 3'd6);
        for (int i = 0; i < 20; i++) begin
            if (grants.size() >= 4) break;
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        chk("tie_grant_count", grants.size(), 4);
        if (grants.size() >= 4)
            chk("tie_grant_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]}, 8'b00_01_00_01);
        wait_idle("tie");

        // Pass with flag, then illegal opcode
        single(1, 32'h1234, 32'd0, 3'd5, 3'd5, "pass");
        single(1, 32'h55, 32'h66, 3'd4, 3'd2, "illegal");

        // Response backpressure
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 10; req0_b = 20; req0_op = 3'd2;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'd1;
        #1;
        chk("bp_exec_req1_ready", req1_ready, 0);
        tick();
        held = rsp0_result;
        chk("bp_first_result", held, 32'd30);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp0_stable", rsp0_result, held);
            chk("bp_busy", busy, 1);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_rsp1_data_zero", {rsp1_valid, rsp1_result}, 0);
            tick();
        end
        rsp0_ready = 1;
        tick();
        chk("bp_req1_granted", req1_ready, 1);
        tick();
        req1_valid = 0;
        wait_idle("bp");

        // Reset during EXEC drops the transaction
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_op = 3'd3;
        tick();
        req1_valid = 0;
        chk("rm_exec_aluop", alu_op, 3'd3);
        reset_n = 0;
        #1;
        q0.delete(); q1.delete(); grants.delete();
        chk("rm_async_busy", busy, 0);
        tick(); tick();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            chk("rm_no_rsp1", rsp1_valid, 0);
            tick();
        end
        req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 3'd0;
        req1_valid = 1; req1_a = 4; req1_b = 6; req1_op = 3'd3;
        #1;
        chk("rm_tie_ready", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (grants.size() >= 2) break;
            tick();
        end
        req1_valid = 0;
        chk("rm_grant_count", grants.size(), 2);
        if (grants.size() >= 2) chk("rm_grant_order", {grants[0][1:0], grants[1][1:0]}, 4'b00_01);
        wait_idle("rm");

        tick();
        chk("sb_q0_empty", q0.size(), 0);
        chk("sb_q1_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
